// File: rtl/mmio_timer_pkg.sv
// Shared constants and register-select type for the memory-mapped timer.
package mmio_timer_pkg;

  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_PRESCALE = 5'h04;
  localparam logic [4:0] ADDR_COMPARE  = 5'h08;
  localparam logic [4:0] ADDR_COUNT    = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_MATCH   = 0;
  localparam int STAT_OVERRUN = 1;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_PRESCALE,
    SEL_COMPARE,
    SEL_COUNT,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_sel(input logic [2:0] word);
    reg_sel_e s;
    s = SEL_NONE;
    unique case (1'b1)
      word == ADDR_CTRL[4:2]:     s = SEL_CTRL;
      word == ADDR_PRESCALE[4:2]: s = SEL_PRESCALE;
      word == ADDR_COMPARE[4:2]:  s = SEL_COMPARE;
      word == ADDR_COUNT[4:2]:    s = SEL_COUNT;
      word == ADDR_STATUS[4:2]:   s = SEL_STATUS;
      default:                    s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into ticks every prescale+1 enabled cycles.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  assign tick = en && (cnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped compare timer: register file, match logic and interrupt.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wd,
  input  logic [31:0] address,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rd,
  output logic        irq
);

  logic [2:0]                ctrl, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [31:0]               compare;
  logic [31:0]               count, count_d;
  logic [1:0]                status, status_d;

  reg_sel_e sel;
  logic     wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_stat;
  logic     tick, hit, pclr;
  logic     unused_addr;

  assign unused_addr = ^{address[31:5], address[1:0]};

  assign sel     = decode_sel(address[4:2]);
  assign wr_ctrl = we && (sel == SEL_CTRL);
  assign wr_pre  = we && (sel == SEL_PRESCALE);
  assign wr_cmp  = we && (sel == SEL_COMPARE);
  assign wr_cnt  = we && (sel == SEL_COUNT);
  assign wr_stat = we && (sel == SEL_STATUS);

  // Phase restarts on a new prescale or a fresh enable.
  assign pclr = wr_pre || (wr_ctrl && wd[CTRL_EN] && !ctrl[CTRL_EN]);

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl[CTRL_EN]),
    .clr     (pclr),
    .prescale(prescale),
    .tick    (tick)
  );

  assign hit = tick && (count == compare);

  always_comb begin
    ctrl_d = ctrl;
    if (wr_ctrl) begin
      ctrl_d = wd[2:0];
    end else if (hit && !ctrl[CTRL_RELOAD]) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end

    count_d = count;
    if (wr_cnt) begin
      count_d = wd;
    end else if (hit) begin
      count_d = ctrl[CTRL_RELOAD] ? 32'h0 : count;
    end else if (tick) begin
      count_d = count + 32'd1;
    end

    // Hardware set outranks a simultaneous write-1-to-clear.
    status_d[STAT_MATCH] = hit |
      (status[STAT_MATCH] & ~(wr_stat & wd[STAT_MATCH]));
    status_d[STAT_OVERRUN] = (hit & status[STAT_MATCH]) |
      (status[STAT_OVERRUN] & ~(wr_stat & wd[STAT_OVERRUN]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '0;
      count    <= '0;
      status   <= '0;
      irq      <= 1'b0;
    end else begin
      ctrl     <= ctrl_d;
      count    <= count_d;
      status   <= status_d;
      irq      <= ctrl_d[CTRL_IRQ_EN] & status_d[STAT_MATCH];
      if (wr_pre) prescale <= wd[PRESCALE_WIDTH-1:0];
      if (wr_cmp) compare <= wd;
    end
  end

  always_comb begin
    rd = 32'h0;
    if (re) begin
      unique case (sel)
        SEL_CTRL:     rd = 32'(ctrl);
        SEL_PRESCALE: rd = 32'(prescale);
        SEL_COMPARE:  rd = compare;
        SEL_COUNT:    rd = count;
        SEL_STATUS:   rd = 32'(status);
        default:      rd = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized bench for mmio_timer against a cycle-level behavioural model.
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wd, address, rd;
  logic        we, re, irq;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] got_rd;
  logic        got_irq;

  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [31:0] m_cmp, m_cnt;
  logic        m_match, m_ovr;
  int          m_phase;

  always #5 clk = ~clk;

  mmio_timer #(.PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .wd(wd), .address(address),
    .we(we), .re(re), .rd(rd), .irq(irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'b0, m_ctrl};
      3'd1:    return {16'b0, m_pre};
      3'd2:    return m_cmp;
      3'd3:    return m_cnt;
      3'd4:    return {30'b0, m_ovr, m_match};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_pre = '0; m_cmp = '0; m_cnt = '0;
    m_match = 1'b0; m_ovr = 1'b0; m_phase = 0;
  endtask

  // One clock of the timer seen from the register map.
  task automatic model_step(input logic w, input logic [2:0] idx,
                            input logic [31:0] d);
    logic        en, reload, tick, ev, clr1, clr0;
    logic [2:0]  n_ctrl;
    logic [31:0] n_cnt;
    int          n_phase;
    en     = m_ctrl[0];
    reload = m_ctrl[1];
    tick   = en && (m_phase == int'(m_pre));
    ev     = tick && (m_cnt == m_cmp);
    if (w && (idx == 3'd1 || (idx == 3'd0 && d[0] && !en))) n_phase = 0;
    else if (tick) n_phase = 0;
    else if (en) n_phase = m_phase + 1;
    else n_phase = m_phase;
    if (w && idx == 3'd3) n_cnt = d;
    else if (ev) n_cnt = reload ? 32'h0 : m_cnt;
    else if (tick) n_cnt = m_cnt + 1;
    else n_cnt = m_cnt;
    if (w && idx == 3'd0) n_ctrl = d[2:0];
    else if (ev && !reload) n_ctrl = {m_ctrl[2:1], 1'b0};
    else n_ctrl = m_ctrl;
    clr0 = w && idx == 3'd4 && d[0];
    clr1 = w && idx == 3'd4 && d[1];
    m_ovr   = (ev && m_match) || (m_ovr && !clr1);
    m_match = ev || (m_match && !clr0);
    if (w && idx == 3'd1) m_pre = d[15:0];
    if (w && idx == 3'd2) m_cmp = d;
    m_cnt = n_cnt; m_ctrl = n_ctrl; m_phase = n_phase;
  endtask

  task automatic cyc(input logic w, input logic r,
                     input logic [2:0] idx, input logic [31:0] d);
    we = w; re = r; wd = d;
    address = {27'($urandom), idx, 2'($urandom)};
    #1;
    got_rd = rd; got_irq = irq;
    check("rd", rd, r ? m_read(idx) : 32'h0);
    check("irq", {31'b0, irq}, {31'b0, m_ctrl[2] & m_match});
    model_step(w, idx, d);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    cyc(1'b1, 1'b0, idx, d);
  endtask

  task automatic rdc(input logic [2:0] idx);
    cyc(1'b0, 1'b1, idx, 32'h0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; we = 1'b0; wd = 32'h0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      re = 1'b1;
      address = {27'($urandom), 3'(i), 2'b00};
      #1;
      check("rst_rd", rd, 32'h0);
    end
    re = 1'b0;
    #1;
    check("rst_rd_re0", rd, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_per[9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  logic [31:0] exp_wrap[8] = '{32'hFFFF_FFFF, 0, 1, 2, 3, 4, 5, 0};

  initial begin
    logic        w, r;
    logic [2:0]  idx;
    logic [31:0] d;
    rst = 1'b1; we = 1'b0; re = 1'b0; wd = '0; address = '0;
    model_reset();
    @(negedge clk);
    reset_pulse();

    // Reset mid-count leaves the timer stopped at zero.
    wr(3'd2, 32'hFF); wr(3'd1, 0); wr(3'd3, 7); wr(3'd0, 1);
    rdc(3'd3); rdc(3'd3);
    reset_pulse();
    for (int k = 0; k < 20; k++) begin
      rdc(3'd3);
      check("rst_hold_cnt", got_rd, 32'h0);
    end

    // Periodic match with prescale 0.
    wr(3'd1, 0); wr(3'd2, 3); wr(3'd3, 0); wr(3'd4, 3); wr(3'd0, 7);
    for (int k = 0; k < 9; k++) begin
      rdc(3'd3);
      check("per_cnt", got_rd, 32'(exp_per[k]));
      check("per_irq", {31'b0, got_irq}, (k >= 4) ? 32'h1 : 32'h0);
    end

    // Prescale 4: one increment per five cycles.
    wr(3'd0, 0); wr(3'd4, 3); wr(3'd2, 32'hFF); wr(3'd3, 0);
    wr(3'd1, 4); wr(3'd0, 1);
    for (int k = 0; k < 11; k++) begin
      rdc(3'd3);
      check("pre_cnt", got_rd, 32'(k / 5));
    end
    wr(3'd1, 4);
    for (int k = 0; k < 7; k++) rdc(3'd3);

    // One-shot stop.
    wr(3'd0, 0); wr(3'd4, 3); wr(3'd1, 0); wr(3'd3, 0);
    wr(3'd2, 2); wr(3'd0, 5);
    for (int k = 0; k < 4; k++) rdc(3'd3);
    rdc(3'd0);
    check("os_ctrl", got_rd, 32'h4);
    rdc(3'd3);
    check("os_cnt", got_rd, 32'h2);
    check("os_irq", {31'b0, got_irq}, 32'h1);
    wr(3'd4, 1);
    rdc(3'd4);
    check("os_irq_clr", {31'b0, got_irq}, 32'h0);
    check("os_stat", got_rd, 32'h0);

    // Collisions: W1C vs match, COUNT write vs tick.
    wr(3'd0, 0); wr(3'd4, 3); wr(3'd1, 0); wr(3'd3, 0);
    wr(3'd2, 1); wr(3'd0, 3);
    rdc(3'd3); rdc(3'd3); rdc(3'd3);
    wr(3'd4, 1);
    rdc(3'd4);
    check("col_stat", got_rd, 32'h3);
    wr(3'd3, 32'h10);
    rdc(3'd3);
    check("col_cnt", got_rd, 32'h10);

    // Wrap from all-ones.
    wr(3'd0, 0); wr(3'd4, 3); wr(3'd1, 0); wr(3'd2, 5);
    wr(3'd3, 32'hFFFF_FFFF); wr(3'd0, 3);
    for (int k = 0; k < 8; k++) begin
      rdc(3'd3);
      check("wrap_cnt", got_rd, exp_wrap[k]);
    end
    rdc(3'd4);
    check("wrap_stat", got_rd, 32'h1);

    for (int k = 0; k < 3000; k++) begin
      idx = 3'($urandom_range(0, 7));
      w   = ($urandom_range(0, 99) < 25);
      r   = ($urandom_range(0, 99) < 80);
      case (idx)
        3'd1:    d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
        3'd2:    d = $urandom_range(0, 8);
        3'd3:    d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD
                                                 : $urandom_range(0, 6);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 499) == 0) reset_pulse();
      else cyc(w, r, idx, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 The block SHALL take one parameter: PRESCALE_WIDTH, default 16, width of the prescaler register and counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port wd, input, 32 bits: write data from the memory map.
REQ-005 The block SHALL have port address, input, 32 bits: byte address from the memory map; only address[4:2] is decoded.
REQ-006 The block SHALL have port we, input, 1 bit: write select; the write commits on the clk edge while high.
REQ-007 The block SHALL have port re, input, 1 bit: read select.
REQ-008 The block SHALL have port rd, output, 32 bits: read data back to the memory map.
REQ-009 The block SHALL have port irq, output, 1 bit: timer interrupt, level.

Function
REQ-010 The block SHALL implement five registers at these word offsets: 0x00 CTRL, 0x04 PRESCALE, 0x08 COMPARE, 0x0C COUNT, 0x10 STATUS.
REQ-011 CTRL SHALL contain EN in bit 0, RELOAD in bit 1 (1 = periodic, 0 = one-shot) and IRQ_EN in bit 2; all other bits read 0.
REQ-012 STATUS SHALL contain MATCH in bit 0 and OVERRUN in bit 1; both are write-1-to-clear, and reads have no side effects.
REQ-013 rd SHALL be combinational, with zero-latency read: the selected register when re=1, 32'h0 when re=0 or for an unmapped offset (0x14-0x1C).
REQ-014 PRESCALE SHALL be PRESCALE_WIDTH bits, zero-extended on read; write data bits above PRESCALE_WIDTH are ignored.
REQ-015 A tick SHALL occur in a cycle where EN=1 and the prescaler counter equals PRESCALE; the prescaler counter then returns to 0, otherwise it increments while EN=1 and holds while EN=0.
REQ-016 With PRESCALE=N, ticks SHALL occur every N+1 cycles; N=0 gives one tick per cycle.
REQ-017 On a tick with COUNT != COMPARE, COUNT SHALL increment modulo 2^32 (0xFFFFFFFF -> 0x0).
REQ-018 On a tick with COUNT == COMPARE (a match event), MATCH SHALL be set; if MATCH was already 1, OVERRUN SHALL also be set.
REQ-019 On a match event with RELOAD=1, COUNT SHALL load 0; with RELOAD=0, COUNT SHALL hold and EN SHALL clear (one-shot stop).
REQ-020 irq SHALL equal IRQ_EN AND MATCH, decoded from registered bits only and glitch-free.
REQ-021 A bus write to a register SHALL take priority over a hardware update of that register in the same cycle (COUNT write beats increment or reload; CTRL write beats one-shot EN clear).
REQ-022 When a W1C write and a hardware set of the same STATUS bit coincide, the set SHALL win.
REQ-023 A write to PRESCALE, or a CTRL write that changes EN from 0 to 1, SHALL reset the prescaler counter to 0.
REQ-024 A CTRL write SHALL take effect from the next cycle: the tick decision in the write cycle uses the old EN.
REQ-025 we and re SHALL be independent; asserting both reads the pre-write value.

Reset
REQ-026 While rst=1, CTRL, PRESCALE, COMPARE, COUNT, STATUS and the prescaler counter SHALL be 0, irq SHALL be 0, and rd SHALL be 0 when re=0.
REQ-027 Reset asserted mid-count SHALL abort counting immediately with no pending match retained; operation SHALL resume only after software re-enables the timer.

Structure
REQ-028 A shared package mmio_timer_pkg SHALL hold the register offset constants, the CTRL/STATUS bit-position constants and the register-select enumeration.
REQ-029 The prescaler SHALL be a sub-module timer_prescaler (inputs en, load-clear, prescale value; output tick); the register file and match logic SHALL stay in mmio_timer.

Verification
REQ-030 Reset mid-operation: run with COUNT=7, assert rst for 1 cycle -> all reads return 0, irq=0, COUNT stays 0 for 20 cycles.
REQ-031 Periodic match: PRESCALE=0, COMPARE=3, write CTRL=0x7 at edge E -> COUNT reads 0,1,2,3 on cycles E+1..E+4, MATCH=1 and irq=1 from E+5, COUNT=0 at E+5, next match at E+9.
REQ-032 Prescaler: PRESCALE=4, COMPARE=0xFF, CTRL=0x1 -> COUNT increments exactly once per 5 cycles; a PRESCALE rewrite restarts the 5-cycle phase.
REQ-033 One-shot: COMPARE=2, CTRL=0x5 -> after the match CTRL reads 0x4, COUNT holds 2, MATCH=1, irq=1; writing STATUS=0x1 clears irq the next cycle.
REQ-034 Collisions: a W1C of MATCH in the same cycle as a match event leaves MATCH=1 with OVERRUN=1; a COUNT write of 0x10 in a tick cycle reads back 0x10.
REQ-035 Wrap: COUNT=0xFFFFFFFF, COMPARE=5, CTRL=0x3 -> COUNT steps to 0x0, then 1..5, and the match occurs 6 ticks after wrap.
